// File: rtl/wt_mem_req_arbiter_if.sv
// Requester, memory-request and return bundle of the write-through request arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding requesters and memory.
interface wt_mem_req_arbiter_if #(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned TidWidth  = 2
);
  localparam int unsigned IdWidth = TidWidth + $clog2(NumPorts);

  logic [NumPorts-1:0]           req_valid;
  logic [NumPorts-1:0]           req_ready;
  logic [NumPorts-1:0]           req_we;
  logic [NumPorts*AddrWidth-1:0] req_addr;
  logic [NumPorts*DataWidth-1:0] req_data;
  logic [NumPorts*TidWidth-1:0]  req_tid;

  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic                          mem_req_we;
  logic [AddrWidth-1:0]          mem_req_addr;
  logic [DataWidth-1:0]          mem_req_data;
  logic [IdWidth-1:0]            mem_req_id;

  logic                          mem_rtrn_valid;
  logic                          mem_rtrn_store;
  logic [IdWidth-1:0]            mem_rtrn_id;
  logic [NumPorts-1:0]           rtrn_valid;
  logic [TidWidth-1:0]           rtrn_tid;

  logic                          stores_pending;
  logic                          store_stall;

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_tid,
    input  mem_req_ready, mem_rtrn_valid, mem_rtrn_store, mem_rtrn_id,
    output req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, mem_req_id,
    output rtrn_valid, rtrn_tid, stores_pending, store_stall
  );

  modport master (
    output req_valid, req_we, req_addr, req_data, req_tid,
    output mem_req_ready, mem_rtrn_valid, mem_rtrn_store, mem_rtrn_id,
    input  req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, mem_req_id,
    input  rtrn_valid, rtrn_tid, stores_pending, store_stall
  );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// Shares the write-through memory request port among requesters (round-robin), tags IDs with the
// source port, throttles outstanding stores and routes returns. Build macro: MEM_ARB_FIXED_PRIO_EN.

// Simulation-only invariants of the arbiter: single accept per cycle, no store-count underflow.
module wt_mem_req_arbiter_chk #(
  parameter int unsigned NumPorts = 3
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic [NumPorts-1:0] req_ready,
  input logic                store_inc,
  input logic                store_dec,
  input logic                cnt_zero
);
  a_single_accept: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready));
  a_no_underflow:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(store_dec && !store_inc && cnt_zero));
endmodule

module wt_mem_req_arbiter #(
  parameter int unsigned NumPorts     = 3,
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned MaxOutStores = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  wt_mem_req_arbiter_if.slave bus
);
  localparam int unsigned    PortW   = $clog2(NumPorts);
  localparam int unsigned    IdWidth = TidWidth + PortW;
  localparam int unsigned    CntW    = $clog2(MaxOutStores + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutStores);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e                 state_r;
`ifndef MEM_ARB_FIXED_PRIO_EN
  localparam logic [PortW:0] PortsExt = (PortW + 1)'(NumPorts);
  logic [PortW-1:0]       rr_ptr_r;
  logic [PortW:0]         cand_s;
`endif
  logic [PortW-1:0]       hold_idx_r;
  logic                   hold_we_r;
  logic [AddrWidth-1:0]   hold_addr_r;
  logic [DataWidth-1:0]   hold_data_r;
  logic [TidWidth-1:0]    hold_tid_r;
  logic [CntW-1:0]        store_cnt_r;
  logic                   stores_pending_r;
  logic                   store_stall_r;

  logic [NumPorts-1:0]    elig_s;
  logic                   sel_found_s;
  logic [PortW-1:0]       sel_idx_s;
  logic                   grant_valid_s;
  logic [PortW-1:0]       grant_idx_s;
  logic                   grant_we_s;
  logic [AddrWidth-1:0]   grant_addr_s;
  logic [DataWidth-1:0]   grant_data_s;
  logic [TidWidth-1:0]    grant_tid_s;
  logic                   accept_s;
  logic [NumPorts-1:0]    req_ready_s;
  logic                   store_inc_s;
  logic                   store_dec_s;
  logic [CntW-1:0]        store_cnt_nxt_s;
  logic [PortW-1:0]       rtrn_port_s;
  logic [NumPorts-1:0]    rtrn_valid_s;

  // Per-port eligibility; a store is masked while the outstanding-store budget is exhausted.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      elig_s[i] = rst_ni & bus.req_valid[i] & ~(bus.req_we[i] & store_stall_r);
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest eligible index wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (!sel_found_s && elig_s[i]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = PortW'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end
`else
  // Round-robin: first eligible port at or after rr_ptr_r, wrapping cyclically.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NumPorts; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (PortW + 1)'(k);
      if (cand_s >= PortsExt) begin
        cand_s = cand_s - PortsExt;
      end else begin
        cand_s = cand_s;
      end
      if (!sel_found_s && elig_s[cand_s[PortW-1:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s[PortW-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end
`endif

  // Grant source: the latched request while holding, otherwise the fresh selection (0-cycle path).
  always_comb begin
    if (state_r == ST_HOLD) begin
      grant_valid_s = 1'b1;
      grant_idx_s   = hold_idx_r;
      grant_we_s    = hold_we_r;
      grant_addr_s  = hold_addr_r;
      grant_data_s  = hold_data_r;
      grant_tid_s   = hold_tid_r;
    end else begin
      grant_valid_s = sel_found_s;
      grant_idx_s   = sel_idx_s;
      grant_we_s    = bus.req_we[sel_idx_s];
      grant_addr_s  = bus.req_addr[sel_idx_s*AddrWidth +: AddrWidth];
      grant_data_s  = bus.req_data[sel_idx_s*DataWidth +: DataWidth];
      grant_tid_s   = bus.req_tid[sel_idx_s*TidWidth +: TidWidth];
    end
  end

  assign accept_s = grant_valid_s & bus.mem_req_ready;

  // One-hot accept strobe back to the granted requester.
  always_comb begin
    for (int i = 0; i < NumPorts; i++) begin
      req_ready_s[i] = accept_s & (grant_idx_s == PortW'(i));
    end
  end

  // Outstanding-store count: simultaneous accept and ack cancel; both ends saturate.
  always_comb begin
    store_inc_s = accept_s & grant_we_s;
    store_dec_s = bus.mem_rtrn_valid & bus.mem_rtrn_store;
    case ({store_inc_s, store_dec_s})
      2'b10:   store_cnt_nxt_s = (store_cnt_r == CntMax) ? store_cnt_r : store_cnt_r + CntW'(1);
      2'b01:   store_cnt_nxt_s = (store_cnt_r == CntW'(0)) ? store_cnt_r : store_cnt_r - CntW'(1);
      default: store_cnt_nxt_s = store_cnt_r;
    endcase
  end

  // Return routing by the port field of the ID; indices beyond NumPorts match no bit and are dropped.
  always_comb begin
    rtrn_port_s = bus.mem_rtrn_id[IdWidth-1:TidWidth];
    for (int i = 0; i < NumPorts; i++) begin
      rtrn_valid_s[i] = rst_ni & bus.mem_rtrn_valid & (rtrn_port_s == PortW'(i));
    end
  end

  // Arbitration FSM, round-robin pointer, latched grant and store bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r          <= ST_IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_ptr_r         <= '0;
`endif
      hold_idx_r       <= '0;
      hold_we_r        <= 1'b0;
      hold_addr_r      <= '0;
      hold_data_r      <= '0;
      hold_tid_r       <= '0;
      store_cnt_r      <= '0;
      stores_pending_r <= 1'b0;
      store_stall_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_found_s && !bus.mem_req_ready) begin
            state_r     <= ST_HOLD;
            hold_idx_r  <= grant_idx_s;
            hold_we_r   <= grant_we_s;
            hold_addr_r <= grant_addr_s;
            hold_data_r <= grant_data_s;
            hold_tid_r  <= grant_tid_s;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (bus.mem_req_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
`ifndef MEM_ARB_FIXED_PRIO_EN
      if (accept_s) begin
        rr_ptr_r <= (grant_idx_s == PortW'(NumPorts - 1)) ? '0 : grant_idx_s + PortW'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
`endif
      store_cnt_r      <= store_cnt_nxt_s;
      stores_pending_r <= (store_cnt_nxt_s != CntW'(0));
      store_stall_r    <= (store_cnt_nxt_s == CntMax);
    end
  end

  assign bus.req_ready      = req_ready_s;
  assign bus.mem_req_valid  = grant_valid_s;
  assign bus.mem_req_we     = grant_valid_s & grant_we_s;
  assign bus.mem_req_addr   = grant_valid_s ? grant_addr_s : '0;
  assign bus.mem_req_data   = grant_valid_s ? grant_data_s : '0;
  assign bus.mem_req_id     = grant_valid_s ? {grant_idx_s, grant_tid_s} : '0;
  assign bus.rtrn_valid     = rtrn_valid_s;
  assign bus.rtrn_tid       = rst_ni ? bus.mem_rtrn_id[TidWidth-1:0] : '0;
  assign bus.stores_pending = stores_pending_r;
  assign bus.store_stall    = store_stall_r;

  wt_mem_req_arbiter_chk #(
    .NumPorts (NumPorts)
  ) u_chk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_ready (req_ready_s),
    .store_inc (store_inc_s),
    .store_dec (store_dec_s),
    .cnt_zero  (store_cnt_r == CntW'(0))
  );
endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Randomized self-checking bench for wt_mem_req_arbiter against a behavioural model of the
// arbitration, store-throttling and return-routing rules.
module tb_wt_mem_req_arbiter;
  localparam int NP  = 3;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TW  = 2;
  localparam int MAX = 7;
  localparam int IW  = TW + $clog2(NP);

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  wt_mem_req_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW)) bus ();

  wt_mem_req_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TidWidth(TW), .MaxOutStores(MAX)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  bit            r_vld  [NP];
  bit            r_we   [NP];
  logic [AW-1:0] r_addr [NP];
  logic [DW-1:0] r_data [NP];
  logic [TW-1:0] r_tid  [NP];

  int m_hold   = -1;
  int m_rr     = 0;
  int m_cnt    = 0;
  int acc_port = -1;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NP; i++) begin
      bus.req_valid[i]          = r_vld[i];
      bus.req_we[i]             = r_we[i];
      bus.req_addr[i*AW +: AW]  = r_addr[i];
      bus.req_data[i*DW +: DW]  = r_data[i];
      bus.req_tid[i*TW +: TW]   = r_tid[i];
    end
  endtask

  task automatic model_reset();
    m_hold = -1; m_rr = 0; m_cnt = 0; acc_port = -1;
    for (int i = 0; i < NP; i++) begin
      r_vld[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0; r_tid[i] = '0;
    end
    drive_reqs();
    bus.mem_req_ready  = 1'b0;
    bus.mem_rtrn_valid = 1'b0;
    bus.mem_rtrn_store = 1'b0;
    bus.mem_rtrn_id    = '0;
  endtask

  // One clock: random stimulus at negedge, compare against the model, advance the model at posedge.
  task automatic one_cycle(input int req_pct, input int rdy_pct, input int ack_pct);
    int g, p, inc, dec;
    logic [NP-1:0] exp_rdy, exp_rt;
    logic [IW-1:0] rid, exp_id;
    @(negedge clk);
    if (acc_port >= 0) begin
      r_vld[acc_port] = 1'b0;
      acc_port = -1;
    end
    for (int i = 0; i < NP; i++) begin
      if (!r_vld[i] && ($urandom_range(99) < req_pct)) begin
        r_vld[i]  = 1'b1;
        r_we[i]   = (i == 2) ? 1'b1 : ((i == 1) ? ($urandom_range(3) == 0) : 1'b0);
        r_addr[i] = {$urandom, $urandom};
        r_data[i] = {$urandom, $urandom};
        r_tid[i]  = TW'($urandom_range(3));
      end
    end
    drive_reqs();
    rid = IW'($urandom_range(15));
    bus.mem_req_ready  = ($urandom_range(99) < rdy_pct);
    bus.mem_rtrn_valid = $urandom_range(1);
    bus.mem_rtrn_id    = rid;
    bus.mem_rtrn_store = bus.mem_rtrn_valid && (m_cnt > 0) && ($urandom_range(99) < ack_pct);
    #1;
    g = -1;
    if (m_hold >= 0) g = m_hold;
    else begin
      for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (g < 0 && r_vld[p] && !(r_we[p] && m_cnt == MAX)) g = p;
      end
    end
    exp_rdy = '0;
    exp_id  = '0;
    if (g >= 0 && bus.mem_req_ready) exp_rdy[g] = 1'b1;
    if (g >= 0) exp_id = IW'(g * (1 << TW) + int'(r_tid[g]));
    check_eq("mem_valid", bus.mem_req_valid, (g >= 0));
    check_eq("req_ready", bus.req_ready, exp_rdy);
    check_eq("mem_we",    bus.mem_req_we,   (g >= 0) ? r_we[g]   : 1'b0);
    check_eq("mem_addr",  bus.mem_req_addr, (g >= 0) ? r_addr[g] : '0);
    check_eq("mem_data",  bus.mem_req_data, (g >= 0) ? r_data[g] : '0);
    check_eq("mem_id",    bus.mem_req_id,   exp_id);
    p = int'(rid) >> TW;
    exp_rt = '0;
    if (bus.mem_rtrn_valid && p < NP) exp_rt[p] = 1'b1;
    check_eq("rtrn_valid",     bus.rtrn_valid, exp_rt);
    check_eq("rtrn_tid",       bus.rtrn_tid, rid % (1 << TW));
    check_eq("stores_pending", bus.stores_pending, (m_cnt != 0));
    check_eq("store_stall",    bus.store_stall, (m_cnt == MAX));
    @(posedge clk);
    inc = 0;
    dec = (bus.mem_rtrn_valid && bus.mem_rtrn_store) ? 1 : 0;
    if (g >= 0) begin
      if (bus.mem_req_ready) begin
        acc_port = g;
        m_hold   = -1;
        inc      = r_we[g] ? 1 : 0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        m_rr     = (g + 1) % NP;
`endif
      end else begin
        m_hold = g;
      end
    end
    m_cnt = m_cnt + inc - dec;
    if (m_cnt < 0) m_cnt = 0;
    if (m_cnt > MAX) m_cnt = MAX;
  endtask

  initial begin
    // Reset window: live requests and a return must not leak to any output.
    model_reset();
    for (int i = 0; i < NP; i++) begin
      r_vld[i] = 1'b1; r_we[i] = (i == 2); r_addr[i] = {$urandom, $urandom}; r_tid[i] = 2'b01;
    end
    drive_reqs();
    bus.mem_req_ready  = 1'b1;
    bus.mem_rtrn_valid = 1'b1;
    bus.mem_rtrn_id    = 4'b0001;
    #12;
    check_eq("rst_mem_valid", bus.mem_req_valid, 1'b0);
    check_eq("rst_req_ready", bus.req_ready, 3'b000);
    check_eq("rst_mem_id",    bus.mem_req_id, 4'b0000);
    check_eq("rst_mem_addr",  bus.mem_req_addr, 64'h0);
    check_eq("rst_rtrn",      bus.rtrn_valid, 3'b000);
    check_eq("rst_pending",   bus.stores_pending, 1'b0);
    check_eq("rst_stall",     bus.store_stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;

    // Return routing of id {2'b10, 2'b11}.
    @(negedge clk);
    bus.mem_rtrn_valid = 1'b1;
    bus.mem_rtrn_id    = 4'b1011;
    #1;
    check_eq("rtrn_route_p2", bus.rtrn_valid, 3'b100);
    check_eq("rtrn_route_tid", bus.rtrn_tid, 2'b11);
    bus.mem_rtrn_valid = 1'b0;

    // Saturated requesters with an always-ready memory, then random traffic with rare acks.
    for (int n = 0; n < 30; n++)  one_cycle(100, 100, 50);
    for (int n = 0; n < 600; n++) one_cycle(60, 60, 5);

    // Enter a held grant, then assert reset asynchronously in the middle of the cycle.
    for (int n = 0; n < 50 && m_hold < 0; n++) one_cycle(90, 0, 0);
    check_eq("hold_reached", (m_hold >= 0), 1'b1);
    @(negedge clk);
    bus.mem_rtrn_valid = 1'b0;
    #1;
    check_eq("hold_valid_pre_rst", bus.mem_req_valid, (m_hold >= 0));
    check_eq("hold_pending_pre_rst", bus.stores_pending, (m_cnt != 0));
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("rst_hold_valid",   bus.mem_req_valid, 1'b0);
    check_eq("rst_hold_ready",   bus.req_ready, 3'b000);
    check_eq("rst_hold_pending", bus.stores_pending, 1'b0);
    check_eq("rst_hold_stall",   bus.store_stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;

    // Random traffic with frequent store acks.
    for (int n = 0; n < 600; n++) one_cycle(50, 50, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
